// File: rtl/uart_tx.sv
// UART transmitter with one-entry holding register.
// Start, data (LSB first), optional parity and stop bits.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int STOP_LEN = OVERSAMPLING * STOP_BITS;
    localparam int CW = $clog2(STOP_LEN);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLING - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] DONE_AT   = CW'(STOP_LEN - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic HAS_PAR = (PARITY != 0);
    localparam logic ODD     = (PARITY == 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d, done_d;
    logic                 accept, load;

    always_comb begin
        accept  = valid_in & ready_out;
        load    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx;
        busy_d  = busy_out;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = full_q;
            end
            ST_START: begin
                if (cnt_q == OS_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            ST_DATA: begin
                if (cnt_q == OS_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (HAS_PAR) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            ST_PAR: begin
                if (cnt_q == OS_LAST) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                done_d = (cnt_q == DONE_AT);
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start is shared by the idle and back-to-back paths
        if (load) begin
            state_d = ST_START;
            cnt_d   = '0;
            shreg_d = hold_q;
            par_d   = (^hold_q) ^ ODD;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end

        hold_d = accept ? data_in : hold_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (load) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            ready_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            par_q     <= par_d;
            tx        <= tx_d;
            busy_out  <= busy_d;
            done_out  <= done_d;
            ready_out <= ~full_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations, each with a
// frame-level reference model and directed literal checks.
module tb_uart_tx;

    logic clk;
    int   vectors;
    int   miscompares;
    int   fin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int OS = (g == 0) ? 16 : ((g == 1) ? 4 : 3);
        localparam int DB = (g == 2) ? 5 : 8;
        localparam int SB = (g == 1) ? 2 : 1;
        localparam int PM = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int LEN = (g == 0) ? 160 : ((g == 1) ? 48 : 24);
        localparam int SAMP = (g == 0) ? 25 : ((g == 1) ? 38 : 20);
        localparam logic SAMP_V = (g == 2) ? 1'b0 : 1'b1;
        localparam logic [15:0] BYTE = (g == 0) ? 16'h55 : 16'h07;
        localparam int RC = (g == 0) ? 3000 : 1500;

        logic          n_rst;
        logic          valid;
        logic [DB-1:0] data;
        logic          rdy;
        logic          txl;
        logic          busy;
        logic          done;

        uart_tx #(
            .DATA_BITS(DB),
            .STOP_BITS(SB),
            .OVERSAMPLING(OS),
            .PARITY(PM)
        ) u_dut (
            .clk(clk),
            .n_rst(n_rst),
            .valid_in(valid),
            .data_in(data),
            .ready_out(rdy),
            .tx(txl),
            .busy_out(busy),
            .done_out(done)
        );

        // per-cycle line values {tx, done} still to be shown
        logic [1:0]    wave[$];
        logic          pend_v = 1'b0;
        logic [DB-1:0] pend_d;
        logic          rdy_m = 1'b0;
        logic          live = 1'b0;

        task automatic add_frame(input logic [DB-1:0] d);
            int   ones;
            logic pb;
            ones = $countones(d);
            for (int k = 0; k < OS; k++) wave.push_back(2'b00);
            for (int i = 0; i < DB; i++)
                for (int k = 0; k < OS; k++)
                    wave.push_back({d[i], 1'b0});
            if (PM != 0) begin
                pb = (PM == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
                for (int k = 0; k < OS; k++) wave.push_back({pb, 1'b0});
            end
            for (int k = 0; k < OS * SB; k++)
                wave.push_back({1'b1, k == OS * SB - 1});
        endtask

        always @(posedge clk) begin
            if (!n_rst) begin
                wave.delete();
                pend_v = 1'b0;
                rdy_m  = 1'b0;
                live   = 1'b1;
            end else begin
                if (wave.size() > 0) void'(wave.pop_front());
                if (wave.size() == 0 && pend_v) begin
                    add_frame(pend_d);
                    pend_v = 1'b0;
                end
                if (valid && rdy_m) begin
                    pend_v = 1'b1;
                    pend_d = data;
                end
                rdy_m = !pend_v;
            end
        end

        always @(negedge clk) begin
            if (live) begin
                chk($sformatf("cfg%0d tx", g), 32'(txl),
                    32'(wave.size() > 0 ? wave[0][1] : 1'b1));
                chk($sformatf("cfg%0d done", g), 32'(done),
                    32'(wave.size() > 0 ? wave[0][0] : 1'b0));
                chk($sformatf("cfg%0d busy", g), 32'(busy),
                    32'(wave.size() > 0));
                chk($sformatf("cfg%0d ready", g), 32'(rdy), 32'(rdy_m));
            end
        end

        initial begin
            logic [15:0] bt;
            int first_low, done_cyc, done_cnt, samp, idle_busy;
            int lows, dones;
            bt = BYTE;
            n_rst = 1'b0;
            valid = 1'b0;
            data  = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("cfg%0d rst ready", g), 32'(rdy), 0);
            chk($sformatf("cfg%0d rst tx", g), 32'(txl), 1);
            chk($sformatf("cfg%0d rst busy", g), 32'(busy), 0);
            chk($sformatf("cfg%0d rst done", g), 32'(done), 0);
            n_rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cfg%0d ready after rst", g), 32'(rdy), 1);

            data  = bt[DB-1:0];
            valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            first_low = 0;
            done_cyc  = 0;
            done_cnt  = 0;
            samp      = 2;
            idle_busy = 2;
            for (int c = 1; c <= LEN + 2; c++) begin
                @(posedge clk);
                @(negedge clk);
                data = DB'($urandom);
                if (txl == 1'b0 && first_low == 0) first_low = c;
                if (done) begin
                    done_cyc = c;
                    done_cnt++;
                end
                if (c == SAMP) samp = int'(txl);
                if (c == LEN + 1) idle_busy = int'(busy);
            end
            chk($sformatf("cfg%0d start latency", g), first_low, 1);
            chk($sformatf("cfg%0d done cycle", g), done_cyc, LEN);
            chk($sformatf("cfg%0d done count", g), done_cnt, 1);
            chk($sformatf("cfg%0d sampled bit", g), samp, 32'(SAMP_V));
            chk($sformatf("cfg%0d busy after", g), idle_busy, 0);

            for (int c = 0; c < RC; c++) begin
                @(negedge clk);
                if (((c / 200) % 2) == 0)
                    valid = ($urandom_range(3) != 0);
                else
                    valid = ($urandom_range(49) == 0);
                data  = DB'($urandom);
                n_rst = ($urandom_range(999) != 0);
            end
            @(negedge clk);
            valid = 1'b0;
            n_rst = 1'b1;
            repeat (2 * LEN + 4) @(negedge clk);

            // abort during data bit 3 with a second byte held
            bt    = 16'h81;
            data  = bt[DB-1:0];
            valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bt   = 16'h3C;
            data = bt[DB-1:0];
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            repeat (4 * OS) @(negedge clk);
            chk($sformatf("cfg%0d bit3 low", g), 32'(txl), 0);
            n_rst = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d abort tx", g), 32'(txl), 1);
            chk($sformatf("cfg%0d abort ready", g), 32'(rdy), 0);
            chk($sformatf("cfg%0d abort done", g), 32'(done), 0);
            @(negedge clk);
            n_rst = 1'b1;
            lows  = 0;
            dones = 0;
            for (int c = 0; c < 2 * LEN + 4; c++) begin
                @(negedge clk);
                data = DB'($urandom);
                if (!txl) lows++;
                if (done) dones++;
            end
            chk($sformatf("cfg%0d post-abort lows", g), lows, 0);
            chk($sformatf("cfg%0d post-abort dones", g), dones, 0);
            fin++;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        fin         = 0;
        for (int i = 0; i < 30000 && fin < 3; i++) @(posedge clk);
        if (fin < 3) chk("finish timeout", 32'(fin), 3);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
